// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: stall bus encodings, stall patterns and FSM state type for stall_ctrl
package stall_ctrl_pkg;
  localparam int STALL_BUS = 4;
  localparam logic STOP = 1'b1;
  localparam logic NOSTOP = 1'b0;
  localparam logic [STALL_BUS-1:0] STALL_NONE = 4'b0000;
  localparam logic [STALL_BUS-1:0] STALL_ID = 4'b0011;
  localparam logic [STALL_BUS-1:0] STALL_DIV = 4'b0111;
  localparam logic [STALL_BUS-1:0] STALL_MEM = 4'b1111;
  typedef enum logic [1:0] {SC_IDLE = 2'd0, SC_DIV = 2'd1, SC_MEM = 2'd2} sc_state_t;
endpackage

// File: rtl/stall_timer.sv
// stall_timer: loadable 8-bit down-counter with zero flag, shared by divide and mem-wait timing
module stall_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt,
  output logic       zero
);
  always_ff @(posedge clk)
    cnt <= rst ? 8'd0 : load ? load_val : dec ? cnt - 8'd1 : cnt;
  assign zero = (cnt == 8'd0);
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: priority stall generator (MEM wait > EXE divide > ID load-use).
// Optional STALL_PERF_CNT_EN adds a saturating stall_cycles counter output.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int STALL_W = 4,
  parameter int DIV_CYCLES = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               id_stallreq,
  input  logic               exe_div_start,
  input  logic               mem_req,
  input  logic               mem_ack,
  output logic [STALL_W-1:0] stall,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic               exe_div_done,
  output logic               mem_err,
  output logic               busy
);
  localparam logic [7:0] MEM_LOAD = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);
  sc_state_t state, state_next;
  logic [7:0] cnt, load_val;
  logic zero, load, dec, mem_wait, mem_on, div_on;
  assign mem_wait = mem_req & ~mem_ack;
  stall_timer u_timer (
    .clk(cpu_clk_50M),
    .rst(cpu_rst),
    .load(load),
    .load_val(load_val),
    .dec(dec),
    .cnt(cnt),
    .zero(zero)
  );
  always_ff @(posedge cpu_clk_50M)
    state <= cpu_rst ? SC_IDLE : state_next;
  always_comb begin
    state_next = state;
    load = 1'b0;
    load_val = MEM_LOAD;
    dec = 1'b0;
    case (state)
      SC_IDLE: begin
        state_next = mem_wait ? SC_MEM : exe_div_start ? SC_DIV : SC_IDLE;
        load = mem_wait | exe_div_start;
        load_val = mem_wait ? MEM_LOAD : DIV_LOAD;
      end
      // a wait arriving mid-divide is only taken up once the divide finishes
      SC_DIV: begin
        state_next = zero ? (mem_wait ? SC_MEM : SC_IDLE) : SC_DIV;
        load = zero & mem_wait;
        dec = ~zero;
      end
      SC_MEM: begin
        state_next = (mem_wait & ~zero) ? SC_MEM : SC_IDLE;
        dec = mem_wait & ~zero;
      end
      default: state_next = SC_IDLE;
    endcase
  end
  always_comb begin
    mem_on = mem_wait & ~(state == SC_MEM & zero);
    div_on = (state == SC_DIV) | (state == SC_IDLE & exe_div_start);
    stall = STALL_W'(mem_on ? STALL_MEM : div_on ? STALL_DIV : id_stallreq ? STALL_ID : STALL_NONE);
    exe_div_done = (state == SC_DIV) & zero;
    mem_err = (state == SC_MEM) & zero & mem_wait;
    busy = (state != SC_IDLE);
  end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge cpu_clk_50M)
    stall_cycles <= cpu_rst ? 32'd0 : ((|stall) & ~(&stall_cycles)) ? stall_cycles + 32'd1 : stall_cycles;
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: vector-table and scoreboard bench for stall_ctrl (DIV_CYCLES=16, MEM_TIMEOUT=4)
module tb_stall_ctrl;
  typedef struct {
    bit rst, id, div, req, ack;
    logic [3:0] s;
    bit done, err, busy;
  } vec_t;
  logic clk = 1'b0;
  logic rst, id, div, req, ack;
  logic [3:0] stall;
  logic done, err, busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] snap;
`endif
  int tests = 0;
  int fails = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  stall_ctrl #(.STALL_W(4), .DIV_CYCLES(16), .MEM_TIMEOUT(4)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst(rst),
    .id_stallreq(id),
    .exe_div_start(div),
    .mem_req(req),
    .mem_ack(ack),
    .stall(stall),
`ifdef STALL_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .exe_div_done(done),
    .mem_err(err),
    .busy(busy)
  );
  function automatic vec_t v(bit r, bit i, bit d, bit q, bit a, logic [3:0] s, bit dn, bit e, bit b);
    vec_t x;
    x.rst = r; x.id = i; x.div = d; x.req = q; x.ack = a;
    x.s = s; x.done = dn; x.err = e; x.busy = b;
    return x;
  endfunction
  task automatic step(input string name, input vec_t x);
    vec_t e;
    @(posedge clk);
    #1;
    rst = x.rst; id = x.id; div = x.div; req = x.req; ack = x.ack;
    exp_q.push_back(x);
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (stall !== e.s || done !== e.done || err !== e.err || busy !== e.busy) begin
      fails++;
      $display("FAIL %s: got stall=%b done=%b err=%b busy=%b, want stall=%b done=%b err=%b busy=%b",
               name, stall, done, err, busy, e.s, e.done, e.err, e.busy);
    end
  endtask
  initial begin
    rst = 1'b1; id = 0; div = 0; req = 0; ack = 0;
    repeat (2) @(posedge clk);
    // reset, load-use, mem ack, mem timeout, triple request, same-cycle ack, req drop
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 4'b0011,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,1));
    tbl.push_back(v(0,0,0,1,1, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,1));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,1));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,1));
    tbl.push_back(v(0,0,0,1,0, 4'b0000,0,1,1));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,1,1,0, 4'b1111,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    tbl.push_back(v(0,0,0,1,1, 4'b0000,0,0,0));
    tbl.push_back(v(0,1,0,1,1, 4'b0011,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 4'b0011,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 4'b0000,0,0,0));
    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);
`ifdef STALL_PERF_CNT_EN
    snap = stall_cycles;
`endif
    // plain divide, with ignored re-start and masked load-use inside
    step("div_T", v(0,0,1,0,0, 4'b0111,0,0,0));
    for (int i = 1; i < 15; i++) step($sformatf("div_T+%0d", i), v(0,i==5,i==3,0,0, 4'b0111,0,0,1));
    step("div_done", v(0,0,0,0,0, 4'b0111,1,0,1));
    step("div_after", v(0,0,0,0,0, 4'b0000,0,0,0));
`ifdef STALL_PERF_CNT_EN
    tests++;
    if (stall_cycles - snap !== 32'd16) begin
      fails++;
      $display("FAIL perf_cnt: got %0d, want 16", stall_cycles - snap);
    end
`endif
    // mem wait arriving during divide: divide runs to completion, then MEM_WAIT
    step("dm_T", v(0,0,1,0,0, 4'b0111,0,0,0));
    for (int i = 1; i < 15; i++) step($sformatf("dm_T+%0d", i), v(0,0,0,i>=3,0, i>=3 ? 4'b1111 : 4'b0111,0,0,1));
    step("dm_done", v(0,0,0,1,0, 4'b1111,1,0,1));
    step("dm_memwait", v(0,0,0,1,0, 4'b1111,0,0,1));
    step("dm_ack", v(0,0,0,1,1, 4'b0000,0,0,1));
    step("dm_idle", v(0,0,0,0,0, 4'b0000,0,0,0));
    // reset at cnt=7 aborts the divide
    step("rd_T", v(0,0,1,0,0, 4'b0111,0,0,0));
    for (int i = 1; i < 8; i++) step($sformatf("rd_T+%0d", i), v(0,0,0,0,0, 4'b0111,0,0,1));
    step("rd_rst", v(1,0,0,0,0, 4'b0111,0,0,1));
    step("rd_after", v(0,0,0,0,0, 4'b0000,0,0,0));
    step("rd_after2", v(0,0,0,0,0, 4'b0000,0,0,0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
